// File: rtl/lut_m_encode_if.sv
// Request/response and table-write bundle for lut_m_encode.
// The master drives writes and requests; the slave (encoder) returns responses.
interface lut_m_encode_if #(
    parameter int PW = 5,
    parameter int AW = 8
);
    logic          wr_en;
    logic [PW-1:0] wr_ptr;
    logic [AW-1:0] wr_adr;
    logic          req_valid;
    logic [AW-1:0] req_adr;
    logic          req_ready;
    logic          rsp_valid;
    logic          rsp_hit;
    logic [PW-1:0] rsp_ptr;

    modport master (
        output wr_en, wr_ptr, wr_adr, req_valid, req_adr,
        input  req_ready, rsp_valid, rsp_hit, rsp_ptr
    );

    modport slave (
        input  wr_en, wr_ptr, wr_adr, req_valid, req_adr,
        output req_ready, rsp_valid, rsp_hit, rsp_ptr
    );
endinterface

// File: rtl/lut_m_encode.sv
// Address-to-pointer encoder: sequential search of a software-loaded address table.
// Define LUT_M_ENCODE_LASTHIT_EN to add a last-hit shortcut for repeated lookups.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a request; req_ready high
// SCAN  | compare key against entry[idx], one entry per cycle
// DONE  | one-cycle response pulse on rsp_valid, then back to IDLE
module lut_m_encode #(
    parameter int DEPTH = 32,
    parameter int PW    = 5,
    parameter int AW    = 8
) (
    input  logic CLK,
    input  logic reset_n,
    lut_m_encode_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t         state;
    logic [AW-1:0]  entry [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [AW-1:0]  key;
    logic [PW-1:0]  idx;
    logic           rsp_valid_q;
    logic           rsp_hit_q;
    logic [PW-1:0]  rsp_ptr_q;

    logic cur_match;
    logic last_idx;
    logic short_hit;

    assign cur_match = valid[idx] && (entry[idx] == key);
    assign last_idx  = (idx == PW'(DEPTH - 1));

    // Entry data needs no reset: the valid bits gate every compare.
    always_ff @(posedge CLK) begin
        if (bus.wr_en)
            entry[bus.wr_ptr] <= bus.wr_adr;
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n)
            valid <= '0;
        else if (bus.wr_en)
            valid[bus.wr_ptr] <= 1'b1;
    end

`ifdef LUT_M_ENCODE_LASTHIT_EN
    logic          lh_valid;
    logic [AW-1:0] lh_adr;
    logic [PW-1:0] lh_ptr;

    assign short_hit = lh_valid && (bus.req_adr == lh_adr);

    // A concurrent write can make a freshly found hit stale or no longer the lowest index.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            lh_valid <= 1'b0;
            lh_adr   <= '0;
            lh_ptr   <= '0;
        end else if (state == SCAN && cur_match) begin
            lh_adr   <= key;
            lh_ptr   <= idx;
            lh_valid <= !(bus.wr_en && ((bus.wr_ptr == idx) ||
                          ((bus.wr_adr == key) && (bus.wr_ptr < idx))));
        end else if (bus.wr_en && ((bus.wr_ptr == lh_ptr) ||
                     ((bus.wr_adr == lh_adr) && (bus.wr_ptr < lh_ptr)))) begin
            lh_valid <= 1'b0;
        end
    end
`else
    assign short_hit = 1'b0;
`endif

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            key         <= '0;
            idx         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_ptr_q   <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        key <= bus.req_adr;
                        idx <= '0;
                        if (short_hit) begin
`ifdef LUT_M_ENCODE_LASTHIT_EN
                            rsp_ptr_q   <= lh_ptr;
`endif
                            rsp_hit_q   <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            state       <= DONE;
                        end else begin
                            state <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (cur_match) begin
                        rsp_hit_q   <= 1'b1;
                        rsp_ptr_q   <= idx;
                        rsp_valid_q <= 1'b1;
                        state       <= DONE;
                    end else if (last_idx) begin
                        rsp_hit_q   <= 1'b0;
                        rsp_ptr_q   <= '0;
                        rsp_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Gating with reset_n keeps req_ready low for the whole reset window.
    assign bus.req_ready = reset_n && (state == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_hit   = rsp_hit_q;
    assign bus.rsp_ptr   = rsp_ptr_q;
endmodule
